display_scan_ctrl: RTL

- Time-multiplexed scan controller for the fuel-pump multi-digit 7-segment display (litres / price readouts).
- Shares one seven_segment_display decoder across NUM_DIGITS common-anode digits, one digit at a time.
- Inserts a guard (all-off) interval between digits to prevent ghosting.
- Double-buffers the BCD value so a frame never shows a mix of old and new digits.

---
 rtl/display_pkg.sv | 14 +
 rtl/seven_segment_display.sv | 32 +++
 rtl/display_scan_ctrl.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the multi-digit 7-segment scan controller.
package display_pkg;

  typedef enum logic {SHOW, GUARD} scan_state_t;

  typedef logic [3:0] bcd_t;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  function automatic logic bcd_valid(input bcd_t digit);
    return (digit <= 4'd9);
  endfunction

endpackage

// File: rtl/seven_segment_display.sv
// BCD/hex to 7-segment decoder; segments {a,b,c,d,e,f,g}, active-high.
module seven_segment_display
  import display_pkg::*;
(
  input  bcd_t       i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_digit)
      4'h0: o_seg = 7'b1111110;
      4'h1: o_seg = 7'b0110000;
      4'h2: o_seg = 7'b1101101;
      4'h3: o_seg = 7'b1111001;
      4'h4: o_seg = 7'b0110011;
      4'h5: o_seg = 7'b1011011;
      4'h6: o_seg = 7'b1011111;
      4'h7: o_seg = 7'b1110000;
      4'h8: o_seg = 7'b1111111;
      4'h9: o_seg = 7'b1111011;
      4'hA: o_seg = 7'b1110111;
      4'hB: o_seg = 7'b0011111;
      4'hC: o_seg = 7'b1001110;
      4'hD: o_seg = 7'b0111101;
      4'hE: o_seg = 7'b1001111;
      4'hF: o_seg = 7'b1000111;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode multi-digit display with
// guard intervals and a double-buffered BCD value. Optional: LEADING_ZERO_BLANK_EN.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GUARD_CYC   = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value_in,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg,
  output logic                    frame_done,
  output logic                    pending
);

  localparam int MAX_PH = (REFRESH_DIV > GUARD_CYC) ? REFRESH_DIV : GUARD_CYC;
  localparam int CNT_W  = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_DIGIT = IDX_W'(NUM_DIGITS - 1);

  scan_state_t             r_state;
  scan_state_t             w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [IDX_W-1:0]        r_idx;
  logic [IDX_W-1:0]        w_idx_nxt;
  logic                    w_wrap;

  logic [4*NUM_DIGITS-1:0] r_shadow;
  logic [4*NUM_DIGITS-1:0] r_active;
  logic                    r_pending;
  logic [4*NUM_DIGITS-1:0] w_shadow_nxt;
  logic [4*NUM_DIGITS-1:0] w_active_nxt;
  logic                    w_pending_nxt;

  logic [NUM_DIGITS-1:0]   r_an_n;
  logic [6:0]              r_seg;
  logic                    r_frame_done;
  logic [NUM_DIGITS-1:0]   w_an_nxt;
  logic [6:0]              w_seg_nxt;

  bcd_t                    w_digit;
  logic [6:0]              w_dec_seg;
  logic                    w_lz_blank;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= SHOW;
      r_cnt   <= '0;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_wrap      = 1'b0;
    if (r_state == SHOW) begin
      if (r_cnt == SHOW_LAST) begin
        w_state_nxt = GUARD;
        w_cnt_nxt   = '0;
      end
    end else begin
      if (r_cnt == GUARD_LAST) begin
        w_state_nxt = SHOW;
        w_cnt_nxt   = '0;
        if (r_idx == LAST_DIGIT) begin
          w_idx_nxt = '0;
          w_wrap    = 1'b1;
        end else begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end
      end
    end
  end

  // Buffer swap happens in the cycle frame_done is visible, so a load in that
  // same cycle goes straight to the active register and shows in the next SHOW.
  always_comb begin
    w_shadow_nxt  = r_shadow;
    w_active_nxt  = r_active;
    w_pending_nxt = r_pending;
    if (r_frame_done) begin
      if (load) begin
        w_active_nxt = value_in;
        w_shadow_nxt = value_in;
      end else if (r_pending) begin
        w_active_nxt = r_shadow;
      end
      w_pending_nxt = 1'b0;
    end else if (load) begin
      w_shadow_nxt  = value_in;
      w_pending_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shadow  <= '0;
      r_active  <= '0;
      r_pending <= 1'b0;
    end else begin
      r_shadow  <= w_shadow_nxt;
      r_active  <= w_active_nxt;
      r_pending <= w_pending_nxt;
    end
  end

  assign w_digit = w_active_nxt[{r_idx, 2'b00} +: 4];

  seven_segment_display u_dec (
    .i_digit (w_digit),
    .o_seg   (w_dec_seg)
  );

`ifdef LEADING_ZERO_BLANK_EN
  // Nibble k and everything above it zero means a leading zero.
  assign w_lz_blank = (r_idx != '0) && ((w_active_nxt >> {r_idx, 2'b00}) == '0);
`else
  assign w_lz_blank = 1'b0;
`endif

  always_comb begin
    w_an_nxt  = '1;
    w_seg_nxt = SEG_BLANK;
    if (r_state == SHOW) begin
      w_an_nxt = ~(NUM_DIGITS'(1) << r_idx);
      if (bcd_valid(w_digit) && !w_lz_blank) begin
        w_seg_nxt = w_dec_seg;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_an_n       <= '1;
      r_seg        <= SEG_BLANK;
      r_frame_done <= 1'b0;
    end else begin
      r_an_n       <= w_an_nxt;
      r_seg        <= w_seg_nxt;
      r_frame_done <= w_wrap;
    end
  end

  assign an_n       = r_an_n;
  assign seg        = r_seg;
  assign frame_done = r_frame_done;
  assign pending    = r_pending;

endmodule
